// File: rtl/temp_monitor_pkg.sv
// temp_monitor_pkg: shared FSM state type and width helpers for temp_monitor.
package temp_monitor_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_e;

  function automatic int acc_w(input int data_w, input int avg_log2);
    return data_w + avg_log2;
  endfunction

  function automatic int idx_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/temp_monitor_hyst.sv
// temp_monitor_hyst: single-channel alarm register with set/clear thresholds.
module temp_monitor_hyst #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic [DATA_W-1:0] avg_i,
  input  logic [DATA_W-1:0] th_hi_i,
  input  logic [DATA_W-1:0] th_lo_i,
  output logic              alarm_o
);

  logic alarm_q, alarm_d;

  // Set is tested first so that an inverted threshold pair favours raising the alarm.
  always_comb alarm_d = !en_i ? alarm_q :
                        (avg_i >= th_hi_i) ? 1'b1 :
                        (avg_i <= th_lo_i) ? 1'b0 : alarm_q;

  always_ff @(posedge clk or negedge rst)
    if (!rst) alarm_q <= 1'b0;
    else      alarm_q <= alarm_d;

  assign alarm_o = alarm_q;

endmodule

// File: rtl/temp_monitor.sv
// temp_monitor: multi-channel snapshot, sequential block averaging and hysteretic alarms.
// Defining TEMP_MONITOR_MINMAX_EN adds per-channel min/max tracking of published averages.
module temp_monitor
  import temp_monitor_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int DATA_W   = 8,
  parameter int AVG_LOG2 = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH*DATA_W-1:0] sensor_in,
  input  logic                     sample_valid,
  input  logic [DATA_W-1:0]        th_hi,
  input  logic [DATA_W-1:0]        th_lo,
  input  logic                     clr_overrun,
  output logic [NUM_CH*DATA_W-1:0] temp_out,
  output logic                     out_valid,
  output logic [NUM_CH-1:0]        alarm,
  output logic                     busy,
  output logic                     overrun
`ifdef TEMP_MONITOR_MINMAX_EN
  ,
  input  logic                     clr_minmax,
  output logic [NUM_CH*DATA_W-1:0] max_out,
  output logic [NUM_CH*DATA_W-1:0] min_out
`endif
);

  localparam int AW = acc_w(DATA_W, AVG_LOG2);
  localparam int IW = idx_w(NUM_CH);
  localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'((1 << AVG_LOG2) - 1);

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [AW-1:0]     acc_t;

  state_e         state_q, state_d;
  logic [IW-1:0]  ch_q, ch_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  data_t          snap_q [NUM_CH];
  data_t          snap_d [NUM_CH];
  data_t          temp_q [NUM_CH];
  data_t          temp_d [NUM_CH];
  acc_t           acc_q  [NUM_CH];
  acc_t           acc_d  [NUM_CH];
  logic           publish, out_valid_q, overrun_q;

  assign busy = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    snap_d  = snap_q;
    acc_d   = acc_q;
    temp_d  = temp_q;
    publish = 1'b0;
    case (state_q)
      IDLE: if (sample_valid) begin
        for (int i = 0; i < NUM_CH; i++) snap_d[i] = sensor_in[i*DATA_W +: DATA_W];
        ch_d    = '0;
        state_d = ACCUM;
      end
      ACCUM: begin
        acc_d[ch_q] = acc_q[ch_q] + AW'(snap_q[ch_q]);
        ch_d        = ch_q + IW'(1);
        state_d     = (ch_q == IW'(NUM_CH - 1)) ? DONE : ACCUM;
      end
      DONE: begin
        publish = (cnt_q == CNT_MAX);
        cnt_d   = publish ? '0 : cnt_q + CW'(1);
        if (publish)
          for (int i = 0; i < NUM_CH; i++) begin
            temp_d[i] = DATA_W'(acc_q[i] >> AVG_LOG2);
            acc_d[i]  = '0;
          end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q     <= IDLE;
      ch_q        <= '0;
      cnt_q       <= '0;
      snap_q      <= '{default: '0};
      acc_q       <= '{default: '0};
      temp_q      <= '{default: '0};
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      cnt_q       <= cnt_d;
      snap_q      <= snap_d;
      acc_q       <= acc_d;
      temp_q      <= temp_d;
      out_valid_q <= publish;
      overrun_q   <= (sample_valid && busy) ? 1'b1 : clr_overrun ? 1'b0 : overrun_q;
    end

  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;

  genvar i;
  generate
    for (i = 0; i < NUM_CH; i++) begin : g_ch
      assign temp_out[i*DATA_W +: DATA_W] = temp_q[i];
      temp_monitor_hyst #(.DATA_W(DATA_W)) u_hyst (
        .clk     (clk),
        .rst     (rst),
        .en_i    (publish),
        .avg_i   (temp_d[i]),
        .th_hi_i (th_hi),
        .th_lo_i (th_lo),
        .alarm_o (alarm[i])
      );
    end
  endgenerate

`ifdef TEMP_MONITOR_MINMAX_EN
  data_t max_q [NUM_CH];
  data_t min_q [NUM_CH];

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      max_q <= '{default: '0};
      min_q <= '{default: '1};
    end else
      for (int k = 0; k < NUM_CH; k++) begin
        max_q[k] <= clr_minmax ? '0 : (publish && temp_d[k] > max_q[k]) ? temp_d[k] : max_q[k];
        min_q[k] <= clr_minmax ? '1 : (publish && temp_d[k] < min_q[k]) ? temp_d[k] : min_q[k];
      end

  genvar m;
  generate
    for (m = 0; m < NUM_CH; m++) begin : g_mm
      assign max_out[m*DATA_W +: DATA_W] = max_q[m];
      assign min_out[m*DATA_W +: DATA_W] = min_q[m];
    end
  endgenerate
`endif

endmodule
